// File: rtl/matrix_mult_ctrl_if.sv
// Bundle of the start/busy/done handshake and the A/B read and C write memory ports.
// The master side belongs to the multiply sequencer, and the slave side to the surrounding memories/host.
interface matrix_mult_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_rdata;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_rdata;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_we;

    modport master (
        input  start, a_rdata, b_rdata,
        output busy, done, a_addr, b_addr, c_addr, c_wdata, c_we
    );

    modport slave (
        output start, a_rdata, b_rdata,
        input  busy, done, a_addr, b_addr, c_addr, c_wdata, c_we
    );
endinterface

// File: rtl/matrix_mult_ctrl.sv
// Sequencer plus MAC computing C = A x B over row-major N x N memories with 1-cycle read latency.
// Define MATMUL_SATURATE_EN to make products and sums saturate to all-ones; by default they wrap mod 2^DATA_W.
module matrix_mult_ctrl #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    matrix_mult_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(N);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  i;
    logic [CNT_W-1:0]  j;
    logic [CNT_W-1:0]  k;
    logic [CNT_W-1:0]  k_addr;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] term;
    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (k == K_LAST) state_next = WRITE;
            WRITE:   state_next = (i == IDX_LAST && j == IDX_LAST) ? DONE : RUN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef MATMUL_SATURATE_EN
    logic [2*DATA_W-1:0] prod_wide;
    logic [DATA_W:0]     sum_wide;

    // An all-ones accumulator absorbs every later term, so saturation sticks for the element.
    always_comb begin
        prod_wide = {{DATA_W{1'b0}}, bus.a_rdata} * {{DATA_W{1'b0}}, bus.b_rdata};
        term      = (|prod_wide[2*DATA_W-1:DATA_W]) ? '1 : prod_wide[DATA_W-1:0];
        sum_wide  = {1'b0, acc} + {1'b0, term};
        sum       = sum_wide[DATA_W] ? '1 : sum_wide[DATA_W-1:0];
    end
`else
    always_comb begin
        term = bus.a_rdata * bus.b_rdata;
        sum  = acc + term;
    end
`endif

    // In RUN cycle k the read data belongs to the address issued at k-1, so accumulation lags by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i   <= '0;
            j   <= '0;
            k   <= '0;
            acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                RUN: begin
                    if (k != '0) acc <= (k == CNT_W'(1)) ? term : sum;
                    if (k != K_LAST) k <= k + CNT_W'(1);
                end
                WRITE: begin
                    k <= '0;
                    if (j == IDX_LAST) begin
                        j <= '0;
                        i <= i + CNT_W'(1);
                    end else begin
                        j <= j + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        k_addr      = (k == K_LAST) ? IDX_LAST : k;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.a_addr  = '0;
        bus.b_addr  = '0;
        bus.c_addr  = '0;
        bus.c_wdata = '0;
        bus.c_we    = 1'b0;
        case (state)
            RUN: begin
                bus.busy   = 1'b1;
                bus.a_addr = ADDR_W'(i) * ADDR_W'(N) + ADDR_W'(k_addr);
                bus.b_addr = ADDR_W'(k_addr) * ADDR_W'(N) + ADDR_W'(j);
            end
            WRITE: begin
                bus.busy    = 1'b1;
                bus.c_we    = 1'b1;
                bus.c_addr  = ADDR_W'(i) * ADDR_W'(N) + ADDR_W'(j);
                bus.c_wdata = acc;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Self-checking bench for matrix_mult_ctrl: behavioural matrix model, synchronous memory model, timing checks.
// Honours MATMUL_SATURATE_EN in its reference model.
module tb_matrix_mult_ctrl;

    localparam int N       = 4;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int NN      = N * N;
    localparam int RUN_CYC = NN * (N + 2);
    localparam int WIN     = RUN_CYC + 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_mult_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    matrix_mult_ctrl #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] mem_a [NN];
    logic [DATA_W-1:0] mem_b [NN];
    logic [DATA_W-1:0] exp_c [NN];

    always @(posedge clk) begin
        bus.a_rdata <= mem_a[bus.a_addr];
        bus.b_rdata <= mem_b[bus.b_addr];
    end

    int compared   = 0;
    int mismatched = 0;

    int                wr_rel  [$];
    logic [ADDR_W-1:0] wr_addr [$];
    logic [DATA_W-1:0] wr_data [$];
    int                done_rel[$];
    bit                busy_tr [WIN];
    logic [46:0]       snap;

    function automatic logic [46:0] outs();
        return {bus.busy, bus.done, bus.c_we, bus.c_addr, bus.c_wdata, bus.a_addr, bus.b_addr};
    endfunction

    task automatic fill(input int pat);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (pat)
                    0: begin
                        mem_a[r*N+c] = (r == c) ? 32'd1 : 32'd0;
                        mem_b[r*N+c] = 32'(r*N + c + 1);
                    end
                    1: begin mem_a[r*N+c] = 32'd2; mem_b[r*N+c] = 32'd3; end
                    2: begin mem_a[r*N+c] = 32'h0001_0000; mem_b[r*N+c] = 32'h0001_0000; end
                    default: begin mem_a[r*N+c] = $urandom; mem_b[r*N+c] = $urandom; end
                endcase
            end
        end
    endtask

    task automatic compute_expected();
        logic [63:0] maxv;
        logic [63:0] s;
        logic [63:0] p;
        maxv = {{(64-DATA_W){1'b0}}, {DATA_W{1'b1}}};
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                s = 64'd0;
                for (int q = 0; q < N; q++) begin
                    p = {32'd0, mem_a[r*N+q]} * {32'd0, mem_b[q*N+c]};
`ifdef MATMUL_SATURATE_EN
                    if (p > maxv) p = maxv;
                    s = s + p;
                    if (s > maxv) s = maxv;
`else
                    s = (s + p) & maxv;
`endif
                end
                exp_c[r*N+c] = s[DATA_W-1:0];
            end
        end
    endtask

    // Caller sits at a negedge; relative cycle 0 is the first RUN cycle after the sampling edge.
    task automatic collect(input bit hold, input int poke_rel, input int rst_rel);
        wr_rel.delete();
        wr_addr.delete();
        wr_data.delete();
        done_rel.delete();
        snap = '0;
        bus.start = 1'b1;
        for (int n = 0; n < WIN; n++) begin
            @(negedge clk);
            if (!hold) bus.start = (n == poke_rel);
            if (n == rst_rel) begin
                rst = 1'b1;
                #1;
                snap = outs();
            end
            if (rst_rel >= 0 && n == rst_rel + 3) rst = 1'b0;
            busy_tr[n] = bus.busy;
            if (bus.c_we) begin
                wr_rel.push_back(n);
                wr_addr.push_back(bus.c_addr);
                wr_data.push_back(bus.c_wdata);
            end
            if (bus.done) done_rel.push_back(n);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        #1;
        compared++;
        if (outs() !== 47'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %0h expected 0", outs());
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (outs() !== 47'd0) begin
            mismatched++;
            $display("[TB] FAIL idle_outputs: got %0h expected 0", outs());
        end
    endtask

    task automatic test_matmul(input int pat, input string name);
        int busy_cnt;
        fill(pat);
        compute_expected();
        collect(1'b0, -1, -1);
        compared++;
        if (wr_rel.size() != NN) begin
            mismatched++;
            $display("[TB] FAIL %s write_count: got %0d expected %0d", name, wr_rel.size(), NN);
        end
        for (int n = 0; n < wr_rel.size() && n < NN; n++) begin
            compared++;
            if (wr_addr[n] !== ADDR_W'(n) || wr_data[n] !== exp_c[n] || wr_rel[n] != n*(N+2) + N + 1) begin
                mismatched++;
                $display("[TB] FAIL %s write[%0d]: got addr=%0d data=%0h cyc=%0d expected addr=%0d data=%0h cyc=%0d",
                         name, n, wr_addr[n], wr_data[n], wr_rel[n], n, exp_c[n], n*(N+2) + N + 1);
            end
        end
        compared++;
        if (done_rel.size() != 1 || done_rel[0] != RUN_CYC) begin
            mismatched++;
            $display("[TB] FAIL %s done_timing: got %0d pulses first at %0d expected 1 at %0d",
                     name, done_rel.size(), (done_rel.size() > 0) ? done_rel[0] : -1, RUN_CYC);
        end
        busy_cnt = 0;
        for (int n = 0; n < WIN; n++) busy_cnt += int'(busy_tr[n]);
        compared++;
        if (busy_cnt != RUN_CYC || busy_tr[RUN_CYC] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s busy_cycles: got %0d (busy at done=%0b) expected %0d (0)",
                     name, busy_cnt, busy_tr[RUN_CYC], RUN_CYC);
        end
    endtask

    task automatic test_start_held();
        int second_done;
        fill(3);
        compute_expected();
        collect(1'b1, -1, -1);
        compared++;
        if (wr_rel.size() != NN || done_rel.size() != 1) begin
            mismatched++;
            $display("[TB] FAIL held writes_dones: got %0d/%0d expected %0d/1", wr_rel.size(), done_rel.size(), NN);
        end
        for (int n = 0; n < wr_rel.size() && n < NN; n++) begin
            compared++;
            if (wr_addr[n] !== ADDR_W'(n) || wr_data[n] !== exp_c[n]) begin
                mismatched++;
                $display("[TB] FAIL held write[%0d]: got addr=%0d data=%0h expected addr=%0d data=%0h",
                         n, wr_addr[n], wr_data[n], n, exp_c[n]);
            end
        end
        compared++;
        if (busy_tr[RUN_CYC+1] !== 1'b0 || busy_tr[RUN_CYC+2] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL held restart: got busy idle=%0b next=%0b expected 0 1",
                     busy_tr[RUN_CYC+1], busy_tr[RUN_CYC+2]);
        end
        second_done = -1;
        for (int n = WIN; n < WIN + RUN_CYC + 10; n++) begin
            @(negedge clk);
            if (bus.done && second_done < 0) second_done = n;
        end
        compared++;
        if (second_done != 2*RUN_CYC + 2) begin
            mismatched++;
            $display("[TB] FAIL held second_done: got %0d expected %0d", second_done, 2*RUN_CYC + 2);
        end
    endtask

    task automatic test_start_while_busy();
        fill(3);
        compute_expected();
        collect(1'b0, 10, -1);
        compared++;
        if (wr_rel.size() != NN || done_rel.size() != 1 || done_rel[0] != RUN_CYC) begin
            mismatched++;
            $display("[TB] FAIL poke summary: got %0d writes %0d dones expected %0d writes 1 done at %0d",
                     wr_rel.size(), done_rel.size(), NN, RUN_CYC);
        end
        for (int n = 0; n < wr_rel.size() && n < NN; n++) begin
            compared++;
            if (wr_addr[n] !== ADDR_W'(n) || wr_data[n] !== exp_c[n] || wr_rel[n] != n*(N+2) + N + 1) begin
                mismatched++;
                $display("[TB] FAIL poke write[%0d]: got addr=%0d data=%0h cyc=%0d expected addr=%0d data=%0h cyc=%0d",
                         n, wr_addr[n], wr_data[n], wr_rel[n], n, exp_c[n], n*(N+2) + N + 1);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int late_busy;
        fill(3);
        compute_expected();
        collect(1'b0, -1, 40);
        compared++;
        if (snap !== 47'd0) begin
            mismatched++;
            $display("[TB] FAIL midrun reset_outputs: got %0h expected 0", snap);
        end
        compared++;
        if (wr_rel.size() != 6 || done_rel.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL midrun writes_dones: got %0d/%0d expected 6/0", wr_rel.size(), done_rel.size());
        end
        late_busy = 0;
        for (int n = 40; n < WIN; n++) late_busy += int'(busy_tr[n]);
        compared++;
        if (late_busy != 0) begin
            mismatched++;
            $display("[TB] FAIL midrun busy_after_reset: got %0d cycles expected 0", late_busy);
        end
        test_matmul(5, "after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_matmul(0, "identity");
        test_matmul(1, "constant");
        test_matmul(2, "wrap");
        test_matmul(3, "random_a");
        test_matmul(4, "random_b");
        test_start_held();
        test_start_while_busy();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
